risc_sequencer: RTL

- Eight-phase control sequencer for the 8-bit accumulator CPU. It drives fetch, decode and execute around the 3-bit-opcode ALU, program counter, instruction register, accumulator and memory.
- It latches the opcode from the instruction register and samples the ALU zero flag. It issues one-hot-timed control strobes to the datapath and memory.
- It stops permanently on HLT until reset.

---
 rtl/risc_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/risc_sequencer.sv
// -----------------------------------------------------------------------------
// risc_sequencer
//   Eight-phase control sequencer for the 8-bit accumulator CPU. Every
//   instruction takes exactly eight clock cycles: the first four fetch the
//   instruction, and the last four address, fetch and execute the operand.
//   The opcode is latched on the edge leaving phase 3. The ALU zero flag is
//   latched on the edge leaving phase 5. All strobes are Moore outputs of the
//   internal registers. HLT stops the sequencer at phase 4 until reset.
//
//   Optional build macro: RISC_SEQ_STEP_EN adds single-step debug through the
//   step_mode and step inputs. The default build has no step ports and
//   free-running behaviour.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   step_mode  in   (RISC_SEQ_STEP_EN only) hold in phase 0 until step
//   step       in   (RISC_SEQ_STEP_EN only) single-cycle release pulse
//   opcode     in   instruction-register opcode field
//   zero       in   ALU is_zero flag
//   sel        out  address mux: 1 = PC, 0 = IR operand address
//   rd         out  memory read enable
//   ld_ir      out  instruction register load
//   inc_pc     out  program counter increment
//   ld_pc      out  program counter load from IR operand
//   ld_ac      out  accumulator load from ALU result
//   wr         out  memory write strobe
//   data_e     out  accumulator drives data bus
//   halt       out  CPU halted (sticky until reset)
//   phase      out  current phase index
// -----------------------------------------------------------------------------
module risc_sequencer #(
  parameter int NUM_PHASES = 8,
  parameter int OP_WIDTH   = 3
) (
  input  logic                clk,
  input  logic                rst,
`ifdef RISC_SEQ_STEP_EN
  input  logic                step_mode,
  input  logic                step,
`endif
  input  logic [OP_WIDTH-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                ld_ac,
  output logic                wr,
  output logic                data_e,
  output logic                halt,
  output logic [2:0]          phase
);

  // The phase counter and its strobe table are built for exactly eight
  // phases. The opcode decode is tied to the three-bit ALU opcode.
  if (NUM_PHASES != 8) begin : g_bad_num_phases
    $error("risc_sequencer: NUM_PHASES must be 8");
  end
  if (OP_WIDTH != 3) begin : g_bad_op_width
    $error("risc_sequencer: OP_WIDTH must be 3");
  end

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  localparam logic [OP_WIDTH-1:0] OP_HLT = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SKZ = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_LDA = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_STO = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_JMP = OP_WIDTH'(7);

  phase_t              r_phase;
  logic [OP_WIDTH-1:0] r_op;
  logic                r_zero;
  logic                r_halted;

  logic w_aluop;
  logic w_hold;

  // Instructions that read an operand and load the accumulator.
  assign w_aluop = (r_op == OP_ADD) || (r_op == OP_AND) ||
                   (r_op == OP_XOR) || (r_op == OP_LDA);

  // Phase 0 is held while step mode waits for a step pulse. No step is
  // remembered outside phase 0, so nothing pending survives reset.
`ifdef RISC_SEQ_STEP_EN
  assign w_hold = step_mode && !step;
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= PH_INST_ADDR;
      r_op     <= OP_HLT;
      r_zero   <= 1'b0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (r_phase == PH_IDLE)     r_op   <= opcode;
      if (r_phase == PH_OP_FETCH) r_zero <= zero;

      if (r_phase == PH_OP_ADDR && r_op == OP_HLT) begin
        // The phase freezes at 4; only reset leaves this state.
        r_halted <= 1'b1;
      end else if (!(r_phase == PH_INST_ADDR && w_hold)) begin
        r_phase <= phase_t'(r_phase + 3'd1);
      end
    end
  end

  // The strobes decode only registered state, so a glitch on opcode or zero
  // cannot reach the datapath. wr is decoded only in phase 7, so a reset
  // earlier in the instruction never leaves a partial write.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (r_halted) begin
      halt = 1'b1;
    end else begin
      case (r_phase)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          // HLT still bumps the PC so that it points past the HLT.
          inc_pc = 1'b1;
          halt   = (r_op == OP_HLT);
        end
        PH_OP_FETCH: begin
          rd = w_aluop;
        end
        PH_ALU_OP: begin
          rd     = w_aluop;
          inc_pc = (r_op == OP_SKZ) && r_zero;
          ld_pc  = (r_op == OP_JMP);
          data_e = (r_op == OP_STO);
        end
        PH_STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          inc_pc = (r_op == OP_JMP);
          ld_pc  = (r_op == OP_JMP);
          wr     = (r_op == OP_STO);
          data_e = (r_op == OP_STO);
        end
      endcase
    end
  end

  assign phase = r_phase;

endmodule
